// File: rtl/des_pkg.sv
// Shared constants and types for the iterative DES Feistel controller.
// Contents: the round count, the IP and FP bit tables and the FSM state enum.
// A table entry at index j names the 1-based DES input bit that drives output
// bit j. Output bit j is bit (64 - j) in DES numbering, so the first entry
// written below is DES output bit 1.
package des_pkg;

  localparam int unsigned DES_ROUNDS = 16;

  typedef logic [63:0][6:0] perm_table_t;

  localparam perm_table_t IP_TABLE = {
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
    7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
    7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
    7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
  };

  localparam perm_table_t FP_TABLE = {
    7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
    7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
    7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
    7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
    7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/des_perm64.sv
// Purely combinational 64-bit bit permutation driven by a DES-style table.
// Ports:
//   src   - 64-bit input word (DES bit 1 = src[63])
//   dst_c - permuted word, combinational
module des_perm64
  import des_pkg::*;
#(
  parameter perm_table_t TABLE = IP_TABLE
) (
  input  logic [63:0] src,
  output logic [63:0] dst_c
);

  // Each output bit is a constant wire from one input bit.
  for (genvar j = 0; j < 64; j++) begin : g_bit
    localparam logic [5:0] SRC_BIT = 6'(64 - int'(TABLE[j]));
    assign dst_c[j] = src[SRC_BIT];
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES Feistel controller placed after a registered round function.
// It accepts a block, applies IP, and runs 16 rounds. Each round waits
// F_LATENCY cycles for f_in, folds f_in into L and swaps the halves. At the
// end it applies FP and holds the result on a valid/ready output.
// Ports:
//   clk, rst                   - clock, async active-high reset
//   in_valid/in_ready/in_dat   - input block handshake
//   in_decrypt                 - direction flag, latched on accept
//   r_dat, key_round           - right half and round index to round function / key schedule
//   key_decrypt                - latched direction flag for the key schedule
//   f_in                       - f-value returned by the round function
//   out_valid/out_ready/out_dat- result handshake
//   busy                       - high whenever not idle
// F_LATENCY is legal in 1..3. The wait counter is 2 bits wide.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int unsigned F_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_dat,
  input  logic        in_decrypt,
  output logic [31:0] r_dat,
  output logic [3:0]  key_round,
  output logic        key_decrypt,
  input  logic [31:0] f_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_dat,
  output logic        busy
);

  localparam logic [1:0] WAIT_LAST  = 2'(F_LATENCY);
  localparam logic [3:0] ROUND_LAST = 4'(DES_ROUNDS - 1);

  state_e      state_q, state_d;
  logic [31:0] l_q, l_d, r_d;
  logic [3:0]  round_d;
  logic [1:0]  wait_q, wait_d;
  logic        dec_d;
  logic [63:0] out_dat_d;
  logic        out_valid_d;
  logic        in_ready_d;
  logic        busy_d;

  logic [63:0] ip_c;
  logic [63:0] fp_c;
  logic [31:0] r_new_c;

  // New right half for the round that completes this cycle.
  assign r_new_c = l_q ^ f_in;

  des_perm64 #(.TABLE(IP_TABLE)) u_ip (
    .src   (in_dat),
    .dst_c (ip_c)
  );

  // FP sees {R16, L16}. This undoes the swap of the last round.
  des_perm64 #(.TABLE(FP_TABLE)) u_fp (
    .src   ({r_new_c, r_dat}),
    .dst_c (fp_c)
  );

  // State and datapath registers. r_dat is the R half register itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      l_q         <= '0;
      r_dat       <= '0;
      key_round   <= '0;
      wait_q      <= '0;
      key_decrypt <= 1'b0;
      out_dat     <= '0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_dat       <= r_d;
      key_round   <= round_d;
      wait_q      <= wait_d;
      key_decrypt <= dec_d;
      out_dat     <= out_dat_d;
      out_valid   <= out_valid_d;
      in_ready    <= in_ready_d;
      busy        <= busy_d;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_dat;
    round_d     = key_round;
    wait_d      = wait_q;
    dec_d       = key_decrypt;
    out_dat_d   = out_dat;
    out_valid_d = out_valid;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          l_d     = ip_c[63:32];
          r_d     = ip_c[31:0];
          dec_d   = in_decrypt;
          round_d = '0;
          wait_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wait_q == WAIT_LAST) begin
          l_d    = r_dat;
          r_d    = r_new_c;
          wait_d = '0;
          if (key_round == ROUND_LAST) begin
            out_dat_d   = fp_c;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            round_d = key_round + 4'd1;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

endmodule

// File: doc/des_round_ctrl.md
# des_round_ctrl

Iterative DES Feistel controller sitting directly downstream of the registered round function `Round`. It accepts a 64-bit block, applies the initial permutation, and drives the right half and round index into the round function. It folds each returned f-value into the left half and swaps halves for 16 rounds, then applies the final permutation and presents the result on a valid/ready output.

## Interface
Parameters:
- `F_LATENCY`, default 1: clock cycles from an `r_dat` change to the matching `f_in`. Legal values are 1..3. Value 1 matches the current round function.

Ports:
- `clk` in, 1: rising-edge clock.
- `rst` in, 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `in_valid` in, 1: input block offered.
- `in_ready` out, 1: controller can accept a block.
- `in_dat` in, 64: plaintext or ciphertext block. DES bit 1 is `in_dat[63]`.
- `in_decrypt` in, 1: direction flag. It is sampled on acceptance and forwarded on `key_decrypt`.
- `r_dat` out, 32: current right half, wired to the round function's `R_dat`.
- `key_round` out, 4: round index 0..15 for the key schedule.
- `key_decrypt` out, 1: latched direction flag for the key schedule.
- `f_in` in, 32: `f_out` from the round function.
- `out_valid` out, 1: result available.
- `out_ready` in, 1: downstream accepts the result.
- `out_dat` out, 64: result block after the final permutation.
- `busy` out, 1: high in every state except IDLE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: {L,R} <= IP(`in_dat`); `key_decrypt` <= `in_decrypt`; round <= 0; wait counter <= 0; go to RUN.
- RUN:
  - `r_dat`=R and `key_round`=round, both held constant for the whole round.
  - The wait counter counts 0..F_LATENCY. In the cycle where the counter equals F_LATENCY, `f_in` is valid, and at the next edge: L <= R; R <= L ^ `f_in`; counter <= 0; round <= round+1.
  - On completion of round 15 (the 16th): `out_dat` <= FP({R16, L16}), where the swap is undone by concatenating the new R before the new L. Also `out_valid` <= 1; go to DONE.
- DONE:
  - `out_valid`=1 and `out_dat` stay stable until `out_ready`=1.
  - On the handshake edge: `out_valid` <= 0; go to IDLE.
- `in_ready` is 0 in RUN and DONE. `in_valid` in those states is ignored, with no buffering.
- Arithmetic: `round` is 4 bits and never wraps, because exit happens at 15. The wait counter is 2 bits. All XOR is bitwise, with no carries.
- Reset values, asynchronous:
  - state=IDLE.
  - L, R, `r_dat`, `out_dat` = 0.
  - `key_round`=0, `key_decrypt`=0.
  - `out_valid`=0.
  - `in_ready`=1 after reset release.
  - `busy`=0.
- Reset during RUN or DONE discards the block; no output is produced.

## Timing
- Call the acceptance edge E0.
- Round k (k=0..15) completes at edge E0 + (k+1)(F_LATENCY+1).
- `out_valid` rises at E0 + 16(F_LATENCY+1). That is 32 cycles for F_LATENCY=1.
- With `out_ready` held high, `out_valid` is high for exactly 1 cycle. `in_ready` rises in the cycle after the output handshake.
- Throughput: one block per 16(F_LATENCY+1)+2 cycles, with no back-pressure.
- `key_round` changes on the same edge as `r_dat`. The key schedule must present `key_dat` combinationally from `key_round`/`key_decrypt`, so that the key and R are aligned at the input register of the round function.
- If `out_ready` is already high when `out_valid` rises, the handshake completes in that same cycle.

## Structure
- Package `des_pkg` holds:
  - IP and FP tables as 64-entry constant arrays, using 1-based DES indices.
  - `DES_ROUNDS`=16.
  - The FSM state enum.
- One sub-module, `des_perm64`: a generic 64-bit permutation parameterised by table. It is instantiated once with IP and once with FP. Both instances are purely combinational; registers stay in `des_round_ctrl`.

## Test plan
- Zero f-function stub (`f_in`=0): `in_dat`=64'h0 → `out_dat`=64'h0. `in_dat`=64'hFFFF_FFFF_FFFF_FFFF → all-ones. `out_valid` must rise exactly 32 cycles after acceptance.
- All-ones f stub with `in_dat`=0: (L,R) cycles with period 4, so after 16 rounds it is back to (0,0) → `out_dat`=0. Check that `r_dat` follows 0, FFFFFFFF, FFFFFFFF, 0, … per round.
- Full chain with the real round function and key schedule, key 64'h133457799BBCDFF1:
  - Encrypt 64'h0123456789ABCDEF → 64'h85E813540F0AB405.
  - Decrypt with `in_decrypt`=1 returns the plaintext.
- Back-pressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `out_dat` stable and `in_ready`=0 throughout. Assert `in_valid` during DONE → no acceptance.
- Reset mid-round (assert `rst` at round 7) → all outputs at reset values immediately. After release, a fresh block completes with correct data and latency.
- F_LATENCY=3 with a delayed stub → `out_valid` at 64 cycles after acceptance. `key_round` held 4 cycles per value, 0..15.
